// File: rtl/dmem_arb_if.sv
// Requester-side bus for dmem_arb: one instance per requester (core, aux).
// master = requester, slave = arbiter.
interface dmem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arb.sv
// Two-requester data memory arbiter: core has fixed priority, aux is guaranteed
// service after STARVE consecutive lost cycles. Read data is registered back.

module dmem_arb_rsp #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd,
    input  logic [DW-1:0] m_rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);
    // rdata only moves on a granted read so the requester can sample it late
    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= rd;
            if (rd) rdata <= m_rdata;
        end
    end
endmodule

module dmem_arb #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int STARVE = 3,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arb_if.slave     c,
    dmem_arb_if.slave     a,
    output logic          stall,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);
    localparam logic [CW-1:0] STARVE_C = CW'(STARVE);

    logic [CW-1:0] wait_cnt;
    logic          a_win;
    logic          c_rd;
    logic          a_rd;

    // STARVE=0 makes the compare true from the first cycle: aux always wins
    assign a_win = a.req & (~c.req | (wait_cnt == STARVE_C));
    assign a.gnt = a_win & reset;
    assign c.gnt = c.req & ~a_win & reset;
    assign stall = c.req & ~c.gnt;

    assign c_rd = c.gnt & ~c.we;
    assign a_rd = a.gnt & ~a.we;

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (a.gnt) begin
            m_we    = a.we;
            m_addr  = a.addr;
            m_wdata = a.wdata;
        end else if (c.gnt) begin
            m_we    = c.we;
            m_addr  = c.addr;
            m_wdata = c.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            wait_cnt <= '0;
        else if (a.gnt || !a.req)
            wait_cnt <= '0;
        else if (wait_cnt != STARVE_C)
            wait_cnt <= wait_cnt + 1'b1;
    end

    dmem_arb_rsp #(.DW(DW)) u_c_rsp (
        .clk     (clk),
        .reset   (reset),
        .rd      (c_rd),
        .m_rdata (m_rdata),
        .rvalid  (c.rvalid),
        .rdata   (c.rdata)
    );

    dmem_arb_rsp #(.DW(DW)) u_a_rsp (
        .clk     (clk),
        .reset   (reset),
        .rd      (a_rd),
        .m_rdata (m_rdata),
        .rvalid  (a.rvalid),
        .rdata   (a.rdata)
    );
endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: STARVE=3 instance with a word memory and read-data
// scoreboard, plus a STARVE=0 instance for the aux-always-wins case.
module tb_dmem_arb;
    localparam logic [31:0] K1 = 32'hA5A5_0000;

    logic clk, reset;
    logic stall, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic stall1, m_we1;
    logic [31:0] m_addr1, m_wdata1, m_rdata1;

    dmem_arb_if #(.AW(32), .DW(32)) cif ();
    dmem_arb_if #(.AW(32), .DW(32)) aif ();
    dmem_arb_if #(.AW(32), .DW(32)) cif1 ();
    dmem_arb_if #(.AW(32), .DW(32)) aif1 ();

    dmem_arb #(.AW(32), .DW(32), .STARVE(3), .CW(4)) dut (
        .clk(clk), .reset(reset), .c(cif), .a(aif), .stall(stall),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    dmem_arb #(.AW(32), .DW(32), .STARVE(0), .CW(4)) dut1 (
        .clk(clk), .reset(reset), .c(cif1), .a(aif1), .stall(stall1),
        .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1)
    );

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    assign m_rdata  = mem[m_addr[9:2]];
    assign m_rdata1 = m_addr1 ^ K1;
    always @(posedge clk) if (m_we) mem[m_addr[9:2]] <= m_wdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] cq[$];
    logic [31:0] aq[$];
    logic [31:0] c_last, a_last;
    logic [3:0]  mwc;

    logic        o_cg, o_ag, o_st, o_mwe;
    logic [31:0] o_maddr, o_mwd;
    logic [3:0]  o_wc;

    // One cycle on the STARVE=3 instance: drive, sample combinational outputs,
    // push expected read data, then compare the registered response.
    task automatic tick(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                        input logic rst);
        logic awin, ag, cg, ecrv, earv;
        logic [31:0] ev;
        cif.req = cr; cif.we = cw; cif.addr = ca; cif.wdata = cd;
        aif.req = ar; aif.we = aw; aif.addr = aa; aif.wdata = ad;
        reset = rst;
        @(negedge clk);
        o_cg = cif.gnt; o_ag = aif.gnt; o_st = stall;
        o_mwe = m_we; o_maddr = m_addr; o_mwd = m_wdata;
        o_wc = dut.wait_cnt;
        checks++;
        if (o_wc !== mwc) begin
            errors++;
            $display("FAIL wait_cnt: got %0d want %0d", o_wc, mwc);
        end
        awin = ar & (~cr | (mwc == 4'd3));
        ag   = awin & rst;
        cg   = cr & ~awin & rst;
        ecrv = cg & ~cw;
        earv = ag & ~aw;
        if (ecrv) cq.push_back(ref_mem[ca[9:2]]);
        if (earv) aq.push_back(ref_mem[aa[9:2]]);
        if (cg && cw) ref_mem[ca[9:2]] = cd;
        if (ag && aw) ref_mem[aa[9:2]] = ad;
        if (!rst || ag || !ar) mwc = 4'd0;
        else if (mwc != 4'd3) mwc = mwc + 4'd1;
        if (!rst) begin
            c_last = 32'd0;
            a_last = 32'd0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (cif.rvalid !== ecrv) begin
            errors++;
            $display("FAIL c_rvalid: got %0b want %0b", cif.rvalid, ecrv);
        end
        if (ecrv && cq.size() > 0) begin
            ev = cq.pop_front();
            c_last = ev;
        end
        checks++;
        if (cif.rdata !== c_last) begin
            errors++;
            $display("FAIL c_rdata: got %h want %h", cif.rdata, c_last);
        end
        checks++;
        if (aif.rvalid !== earv) begin
            errors++;
            $display("FAIL a_rvalid: got %0b want %0b", aif.rvalid, earv);
        end
        if (earv && aq.size() > 0) begin
            ev = aq.pop_front();
            a_last = ev;
        end
        checks++;
        if (aif.rdata !== a_last) begin
            errors++;
            $display("FAIL a_rdata: got %h want %h", aif.rdata, a_last);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        tick(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        checks++;
        if (o_cg !== 1'b0 || o_ag !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got c=%0b a=%0b want 0 0", o_cg, o_ag);
        end
        checks++;
        if (o_st !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got %0b want 1", o_st);
        end
        checks++;
        if (o_mwe !== 1'b0 || o_maddr !== 32'd0 || o_mwd !== 32'd0) begin
            errors++;
            $display("FAIL reset_mbus: got we=%0b addr=%h wdata=%h want 0", o_mwe, o_maddr, o_mwd);
        end
    endtask

    task automatic test_core_only();
        tick(1'b1, 1'b1, 32'd84, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        checks++;
        if (o_cg !== 1'b1 || o_st !== 1'b0) begin
            errors++;
            $display("FAIL core_wr_gnt: got gnt=%0b stall=%0b want 1 0", o_cg, o_st);
        end
        checks++;
        if (o_mwe !== 1'b1 || o_maddr !== 32'd84 || o_mwd !== 32'd7) begin
            errors++;
            $display("FAIL core_wr_mbus: got we=%0b addr=%0d wdata=%0d want 1 84 7", o_mwe, o_maddr, o_mwd);
        end
        tick(1'b1, 1'b0, 32'd84, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        checks++;
        if (cif.rvalid !== 1'b1 || cif.rdata !== 32'd7) begin
            errors++;
            $display("FAIL core_rd_84: got v=%0b data=%0d want 1 7", cif.rvalid, cif.rdata);
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'd0, 1'b1, 1'b0, 32'h40, 32'd0, 1'b1);
            checks++;
            if (o_cg !== (i % 4 != 3) || o_ag !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL contention_gnt[%0d]: got c=%0b a=%0b", i, o_cg, o_ag);
            end
            checks++;
            if (o_st !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL contention_stall[%0d]: got %0b want %0b", i, o_st, (i % 4 == 3));
            end
        end
    endtask

    task automatic test_aux_drop();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 32'h180, 32'd0, 1'b1, 1'b0, 32'h44, 32'd0, 1'b1);
            checks++;
            if (o_ag !== 1'b0 || o_wc !== 4'(i)) begin
                errors++;
                $display("FAIL drop_lost[%0d]: got a_gnt=%0b wc=%0d want 0 %0d", i, o_ag, o_wc, i);
            end
        end
        tick(1'b1, 1'b0, 32'h184, 32'd0, 1'b0, 1'b0, 32'h44, 32'd0, 1'b1);
        checks++;
        if (o_ag !== 1'b0 || o_cg !== 1'b1) begin
            errors++;
            $display("FAIL drop_gnt: got a=%0b c=%0b want 0 1", o_ag, o_cg);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 32'h188, 32'd0, 1'b1, 1'b0, 32'h48, 32'd0, 1'b1);
            checks++;
            if (o_wc !== 4'(i) || o_ag !== (i == 3)) begin
                errors++;
                $display("FAIL drop_restart[%0d]: got wc=%0d a_gnt=%0b", i, o_wc, o_ag);
            end
        end
    endtask

    task automatic test_aux_write();
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd80, 32'h55, 1'b1);
        checks++;
        if (o_ag !== 1'b1 || o_mwe !== 1'b1 || o_maddr !== 32'd80 || o_mwd !== 32'h55) begin
            errors++;
            $display("FAIL aux_wr: got gnt=%0b we=%0b addr=%0d wdata=%h", o_ag, o_mwe, o_maddr, o_mwd);
        end
        tick(1'b1, 1'b0, 32'd80, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        checks++;
        if (cif.rdata !== 32'h55 || aif.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL aux_wr_readback: got c_rdata=%h a_rvalid=%0b want 55 0", cif.rdata, aif.rvalid);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0, 32'h1c0, 32'd0, 1'b1, 1'b0, 32'h4c, 32'd0, 1'b1);
        tick(1'b1, 1'b0, 32'h1c4, 32'd0, 1'b1, 1'b0, 32'h4c, 32'd0, 1'b1);
        tick(1'b1, 1'b0, 32'h1c8, 32'd0, 1'b1, 1'b0, 32'h4c, 32'd0, 1'b0);
        checks++;
        if (o_cg !== 1'b0 || o_ag !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_gnt: got c=%0b a=%0b want 0 0", o_cg, o_ag);
        end
        checks++;
        if (cif.rvalid !== 1'b0 || cif.rdata !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_rsp: got v=%0b data=%h want 0 0", cif.rvalid, cif.rdata);
        end
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        checks++;
        if (o_wc !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_wc: got %0d want 0", o_wc);
        end
    endtask

    task automatic test_starve0();
        logic [31:0] ea;
        for (int i = 0; i < 5; i++) begin
            ea = 32'h200 + 32'(4 * i);
            cif1.req = 1'b1; cif1.we = 1'b0; cif1.addr = 32'h300; cif1.wdata = 32'd0;
            aif1.req = 1'b1; aif1.we = 1'b0; aif1.addr = ea;      aif1.wdata = 32'd0;
            @(negedge clk);
            checks++;
            if (aif1.gnt !== 1'b1 || cif1.gnt !== 1'b0 || stall1 !== 1'b1) begin
                errors++;
                $display("FAIL starve0_gnt[%0d]: got a=%0b c=%0b stall=%0b want 1 0 1", i, aif1.gnt, cif1.gnt, stall1);
            end
            checks++;
            if (m_addr1 !== ea) begin
                errors++;
                $display("FAIL starve0_addr[%0d]: got %h want %h", i, m_addr1, ea);
            end
            @(posedge clk);
            #1;
            checks++;
            if (aif1.rvalid !== 1'b1 || aif1.rdata !== (ea ^ K1) || cif1.rvalid !== 1'b0) begin
                errors++;
                $display("FAIL starve0_rsp[%0d]: got av=%0b ad=%h cv=%0b want 1 %h 0", i, aif1.rvalid, aif1.rdata, cif1.rvalid, ea ^ K1);
            end
        end
        cif1.req = 1'b0;
        aif1.req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i) * 32'h0101_0101 + 32'h1000;
            ref_mem[i] = 32'(i) * 32'h0101_0101 + 32'h1000;
        end
        mwc = 4'd0; c_last = 32'd0; a_last = 32'd0;
        reset = 1'b0;
        cif.req = 1'b0;  cif.we = 1'b0;  cif.addr = '0;  cif.wdata = '0;
        aif.req = 1'b0;  aif.we = 1'b0;  aif.addr = '0;  aif.wdata = '0;
        cif1.req = 1'b0; cif1.we = 1'b0; cif1.addr = '0; cif1.wdata = '0;
        aif1.req = 1'b0; aif1.we = 1'b0; aif1.addr = '0; aif1.wdata = '0;
        test_reset();
        test_core_only();
        test_contention();
        test_aux_drop();
        test_aux_write();
        test_reset_mid();
        test_starve0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
